r16_tf_addr_gen: RTL and testbench

- Generates the 16 per-lane twiddle-factor ROM addresses for one radix-16 butterfly group per beat.
- Addresses feed the twiddle ROM, whose read data drives the TF inputs of the 16-lane twiddle modular multiplier stage.
- Lane k of group j gets address (k*j*stride) mod 2^ADDR_W.
- Sequences all groups of one FFT/NTT stage under a valid/ready handshake with downstream backpressure.

---
 rtl/r16_tf_addr_gen_pkg.sv | 26 ++
 rtl/r16_tf_lane_acc.sv | 48 ++++
 rtl/r16_tf_addr_gen.sv | 113 +++++++++++
 tb/tb_r16_tf_addr_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/r16_tf_addr_gen_pkg.sv
// Shared definitions for the radix-16 twiddle address generator.
// Optional build macro: R16_TF_NEG_EN (half-wave folding; adds tf_neg output).
package r16_tf_addr_gen_pkg;

    localparam int unsigned LANES = 16;

    // State encodings
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

    // Constant multiple k*s built from shifted copies of s (k is 0..15).
    function automatic logic [31:0] shift_add_mul(input logic [31:0] s, input logic [3:0] k);
        logic [31:0] p;
        p = '0;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) p = p + (s << b);
        end
        return p;
    endfunction

endpackage

// File: rtl/r16_tf_lane_acc.sv
// One lane of the twiddle address generator: holds incr = LANE*stride and the
// running address accumulator acc, which advances by incr per accepted beat.
module r16_tf_lane_acc
    import r16_tf_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LANE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] stride,
    input  logic              load,
    input  logic              adv,
    input  logic              clr,
    output logic [ADDR_W-1:0] acc
);

    logic [ADDR_W-1:0] incr_d, incr_q;
    logic [ADDR_W-1:0] acc_d, acc_q;

    // Load a new increment on stage start, otherwise clear or advance the accumulator
    always_comb begin
        incr_d = incr_q;
        acc_d  = acc_q;
        if (load) begin
            incr_d = ADDR_W'(shift_add_mul(32'(stride), 4'(LANE)));
            acc_d  = '0;
        end else if (clr) begin
            acc_d = '0;
        end else if (adv) begin
            acc_d = acc_q + incr_q;   // wraps mod 2^ADDR_W
        end
    end

    // Increment/accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr_q <= '0;
            acc_q  <= '0;
        end else begin
            incr_q <= incr_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/r16_tf_addr_gen.sv
// Radix-16 twiddle-factor ROM address generator: one beat of 16 lane addresses
// (k*j*stride mod 2^ADDR_W) per butterfly group j, with valid/ready backpressure.
// Optional build macro: R16_TF_NEG_EN adds tf_neg and folds addresses to N/2.
module r16_tf_addr_gen
    import r16_tf_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned GRP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        stride,
    input  logic [GRP_W-1:0]         grp_num,
    input  logic                     tf_ready,
    output logic                     tf_valid,
    output logic [LANES*ADDR_W-1:0]  tf_addr,
    output logic [GRP_W-1:0]         grp_idx,
    output logic                     busy,
`ifdef R16_TF_NEG_EN
    output logic [LANES-1:0]         tf_neg,
`endif
    output logic                     done
);

    state_e            state_d, state_q;
    logic [GRP_W-1:0]  grp_d, grp_q;
    logic [GRP_W-1:0]  glast_d, glast_q;   // G-1, index of the final group
    logic              done_d, done_q;
    logic              load, adv, clr;

    logic [LANES-1:0][ADDR_W-1:0] acc;

    // Next-state and lane control
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        glast_d = glast_q;
        done_d  = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (grp_num != '0) begin
                        glast_d = grp_num - GRP_W'(1);
                        grp_d   = '0;
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;   // empty stage: finish without beats
                    end
                end
            end
            RUN: begin
                // tf_valid is always high in RUN, so ready alone means accept
                if (tf_ready) begin
                    if (grp_q == glast_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        grp_d   = '0;
                        clr     = 1'b1;
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                        adv   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            glast_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            glast_q <= glast_d;
            done_q  <= done_d;
        end
    end

    assign tf_valid = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign grp_idx  = grp_q;
    assign done     = done_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        r16_tf_lane_acc #(.ADDR_W(ADDR_W), .LANE(k)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .stride (stride),
            .load   (load),
            .adv    (adv),
            .clr    (clr),
            .acc    (acc[k])
        );
`ifdef R16_TF_NEG_EN
        // MSB selects the negated half of the table; address covers N/2 entries
        assign tf_addr[k*ADDR_W +: ADDR_W] = {1'b0, acc[k][ADDR_W-2:0]};
        assign tf_neg[k] = acc[k][ADDR_W-1];
`else
        assign tf_addr[k*ADDR_W +: ADDR_W] = acc[k];
`endif
    end

endmodule

// File: tb/tb_r16_tf_addr_gen.sv
// Directed self-checking bench for r16_tf_addr_gen (ADDR_W=12, GRP_W=8).
module tb_r16_tf_addr_gen;

    localparam int AW = 12;
    localparam int GW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   stride;
    logic [GW-1:0]   grp_num;
    logic            tf_ready;
    logic            tf_valid;
    logic [16*AW-1:0] tf_addr;
    logic [GW-1:0]   grp_idx;
    logic            busy;
    logic            done;
`ifdef R16_TF_NEG_EN
    logic [15:0]     tf_neg;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    r16_tf_addr_gen #(.ADDR_W(AW), .GRP_W(GW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stride   (stride),
        .grp_num  (grp_num),
        .tf_ready (tf_ready),
        .tf_valid (tf_valid),
        .tf_addr  (tf_addr),
        .grp_idx  (grp_idx),
        .busy     (busy),
`ifdef R16_TF_NEG_EN
        .tf_neg   (tf_neg),
`endif
        .done     (done)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lane(input int k);
        return tf_addr[k*AW +: AW];
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stride = '0; grp_num = '0; tf_ready = 1'b1;
        #2;
        chk("rst_valid", tf_valid, 0);
        chk("rst_addr",  tf_addr, 0);
        chk("rst_grp",   grp_idx, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic stage: s=1, G=4
        start = 1'b1; stride = 12'd1; grp_num = 8'd4;
        tick();
        start = 1'b0;
        chk("b_v0", tf_valid, 1);
        chk("b_busy", busy, 1);
        chk("b_g0", grp_idx, 0);
        chk("b_g0_addr", tf_addr, 0);
        tick();
        chk("b_g1", grp_idx, 1);
        chk("b_g1_l1", lane(1), 1);
        chk("b_g1_l7", lane(7), 7);
        chk("b_g1_l15", lane(15), 15);
        tick();
        chk("b_g2_l9", lane(9), 18);
        tick();
        chk("b_g3", grp_idx, 3);
        chk("b_g3_l15", lane(15), 45);
        chk("b_g3_l0", lane(0), 0);
        chk("b_done_lo", done, 0);
        tick();
        chk("b_end_v", tf_valid, 0);
        chk("b_end_done", done, 1);
        chk("b_end_busy", busy, 0);
        tick();
        chk("b_done_1cyc", done, 0);

        // Wrap: s=300, G=2
        start = 1'b1; stride = 12'd300; grp_num = 8'd2;
        tick();
        start = 1'b0;
        chk("w_g0_addr", tf_addr, 0);
        tick();
        chk("w_g1_l1", lane(1), 300);
        chk("w_g1_l15", lane(15), 404);
        tick();
        chk("w_done", done, 1);
        // New start issued in the done cycle, then backpressure on group 1
        start = 1'b1; stride = 12'd1; grp_num = 8'd4;
        tick();
        start = 1'b0;
        chk("d_start_v", tf_valid, 1);
        chk("d_start_g", grp_idx, 0);
        tick();
        chk("bp_g1", grp_idx, 1);
        tf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // start while busy must be ignored
            start = (i == 1); stride = 12'd7; grp_num = 8'd9;
            tick();
            chk("bp_hold_v", tf_valid, 1);
            chk("bp_hold_g", grp_idx, 1);
            chk("bp_hold_l3", lane(3), 3);
        end
        start = 1'b0;
        tf_ready = 1'b1;
        tick();
        chk("bp_g2", grp_idx, 2);
        chk("bp_g2_l5", lane(5), 10);
        tick();
        chk("bp_g3_l15", lane(15), 45);
        tick();
        chk("bp_end_v", tf_valid, 0);
        chk("bp_end_done", done, 1);
        tick();

        // Empty stage: G=0
        start = 1'b1; stride = 12'd5; grp_num = 8'd0;
        tick();
        start = 1'b0;
        chk("g0_v", tf_valid, 0);
        chk("g0_done", done, 1);
        tick();
        chk("g0_done_lo", done, 0);
        chk("g0_v2", tf_valid, 0);

        // Reset mid-stage at group 2 of G=8
        start = 1'b1; stride = 12'd1; grp_num = 8'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("r_g2", grp_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("r_v", tf_valid, 0);
        chk("r_addr", tf_addr, 0);
        chk("r_grp", grp_idx, 0);
        chk("r_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_no_done", done, 0);
            chk("r_idle_v", tf_valid, 0);
        end
        start = 1'b1; stride = 12'd2; grp_num = 8'd2;
        tick();
        start = 1'b0;
        tick();
        chk("r_re_l3", lane(3), 6);

        // Folding case: s=200, G=2
        tick();
        tick();
        start = 1'b1; stride = 12'd200; grp_num = 8'd2;
        tick();
        start = 1'b0;
        tick();
`ifdef R16_TF_NEG_EN
        chk("n_neg15", tf_neg[15], 1);
        chk("n_l15", lane(15), 952);
        chk("n_neg10", tf_neg[10], 0);
        chk("n_l10", lane(10), 2000);
`else
        chk("n_l15", lane(15), 3000);
        chk("n_l10", lane(10), 2000);
`endif
        tick();
        chk("n_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
